flag_forward_unit: RTL and testbench

Condition-flag producer for the IITB-RISC pipeline. It tracks carry and zero updates from in-flight ALU and load instructions through the EX→MEM→WB stages and commits them to the architectural C/Z register at writeback. It also forwards the youngest valid flag values back to the ALU-control decode, so conditional ADC/ADZ/NDC/NDZ instructions see correct flags without stalling. It sits beside the EX/MEM/WB pipeline registers and drives the decoder's carry_in/zero_in.

---
 rtl/flag_pkg.sv | 22 ++
 rtl/flag_stage_reg.sv | 25 ++
 rtl/flag_forward_unit.sv | 87 ++++++++
 tb/tb_flag_forward_unit.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/flag_pkg.sv
// Shared flag-unit types: ALU control encoding and the pending flag entry.
package flag_pkg;

    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_NAND = 2'b01;
    localparam logic [1:0] ALU_NOP  = 2'b10;

    // One in-flight flag update: which flags it writes and their values.
    typedef struct packed {
        logic valid;
        logic wc;
        logic wz;
        logic c;
        logic z;
    } flag_entry_t;

    // An instruction updates flags only if it is real, not killed, and not suppressed.
    function automatic logic is_exec(input logic valid, input logic kill, input logic [1:0] ctrl);
        return valid & ~kill & (ctrl != ALU_NOP);
    endfunction

endpackage

// File: rtl/flag_stage_reg.sv
// Pipeline register for one pending flag entry; holds on stall, loads a bubble on clear.
module flag_stage_reg
    import flag_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        clear,
    input  flag_entry_t d,
    output flag_entry_t q
);

    // Stall wins over clear so a held flush cannot act during a freeze.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            q <= '0;
        else if (!stall) begin
            if (clear)
                q <= '0;
            else
                q <= d;
        end
    end

endmodule

// File: rtl/flag_forward_unit.sv
// Tracks C/Z updates through MEM/WB, commits them at writeback and forwards
// the youngest pending values to the ALU-control decode.
module flag_forward_unit
    import flag_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       stall,
    input  logic       flush,
    input  logic       ex_valid,
    input  logic [1:0] ex_alu_ctrl,
    input  logic       ex_sets_c,
    input  logic       ex_sets_z,
    input  logic       ex_c,
    input  logic       ex_z,
    input  logic       mem_is_load,
    input  logic       mem_load_z,
    output logic       carry_fwd,
    output logic       zero_fwd,
    output logic       arch_c,
    output logic       arch_z
);

    flag_entry_t ex_entry;
    flag_entry_t m_q;
    flag_entry_t m_eff;
    flag_entry_t w_q;
    logic        exec;
    logic        older_z;

    // Build the entry captured from EX; suppressed or flushed ops become bubbles.
    always_comb begin
        exec           = is_exec(ex_valid, flush, ex_alu_ctrl);
        ex_entry       = '0;
        ex_entry.valid = exec;
        ex_entry.wc    = exec & ex_sets_c;
        ex_entry.wz    = exec & ex_sets_z;
        ex_entry.c     = ex_c;
        ex_entry.z     = ex_z;
    end

    // A load sitting in MEM writes Z from the loaded data.
    always_comb begin
        m_eff = m_q;
        if (m_q.valid && mem_is_load) begin
            m_eff.wz = 1'b1;
            m_eff.z  = mem_load_z;
        end
    end

    flag_stage_reg u_m_stage (
        .clk   (clk),
        .reset (reset),
        .stall (stall),
        .clear (flush),
        .d     (ex_entry),
        .q     (m_q)
    );

    flag_stage_reg u_w_stage (
        .clk   (clk),
        .reset (reset),
        .stall (stall),
        .clear (1'b0),
        .d     (m_eff),
        .q     (w_q)
    );

    // Retire W into the architectural flags on every unstalled edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            arch_c <= 1'b0;
            arch_z <= 1'b0;
        end else if (!stall && w_q.valid) begin
            if (w_q.wc) arch_c <= w_q.c;
            if (w_q.wz) arch_z <= w_q.z;
        end
    end

    // Youngest writer wins; mem_load_z reaches zero_fwd through one final mux.
    always_comb begin
        older_z   = w_q.wz ? w_q.z : arch_z;
        zero_fwd  = m_eff.wz ? m_eff.z : older_z;
        carry_fwd = m_q.wc ? m_q.c : (w_q.wc ? w_q.c : arch_c);
    end

endmodule

// File: tb/tb_flag_forward_unit.sv
// Self-checking bench: directed scenarios then random traffic against an
// in-flight instruction model.
module tb_flag_forward_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic       stall, flush, ex_valid;
    logic [1:0] ex_alu_ctrl;
    logic       ex_sets_c, ex_sets_z, ex_c, ex_z;
    logic       mem_is_load, mem_load_z;
    logic       carry_fwd, zero_fwd, arch_c, arch_z;

    int compares = 0;
    int fails    = 0;

    flag_forward_unit dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .flush       (flush),
        .ex_valid    (ex_valid),
        .ex_alu_ctrl (ex_alu_ctrl),
        .ex_sets_c   (ex_sets_c),
        .ex_sets_z   (ex_sets_z),
        .ex_c        (ex_c),
        .ex_z        (ex_z),
        .mem_is_load (mem_is_load),
        .mem_load_z  (mem_load_z),
        .carry_fwd   (carry_fwd),
        .zero_fwd    (zero_fwd),
        .arch_c      (arch_c),
        .arch_z      (arch_z)
    );

    always #5 clk = ~clk;

    // Reference: in-flight instructions, youngest first ([0] in MEM, [1] in WB).
    typedef struct {
        bit live;
        bit writes_c;
        bit writes_z;
        bit c;
        bit z;
    } instr_t;

    instr_t inflight[2];
    bit     ref_c, ref_z;

    function automatic instr_t mem_view();
        instr_t r = inflight[0];
        if (r.live && mem_is_load) begin
            r.writes_z = 1;
            r.z        = mem_load_z;
        end
        return r;
    endfunction

    function automatic bit exp_carry();
        for (int i = 0; i < 2; i++)
            if (inflight[i].writes_c) return inflight[i].c;
        return ref_c;
    endfunction

    function automatic bit exp_zero();
        instr_t v[2];
        v[0] = mem_view();
        v[1] = inflight[1];
        for (int i = 0; i < 2; i++)
            if (v[i].writes_z) return v[i].z;
        return ref_z;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 2; i++) inflight[i] = '{0, 0, 0, 0, 0};
        ref_c = 0;
        ref_z = 0;
    endtask

    task automatic model_edge();
        instr_t n;
        bit     e;
        if (stall) return;
        if (inflight[1].live) begin
            if (inflight[1].writes_c) ref_c = inflight[1].c;
            if (inflight[1].writes_z) ref_z = inflight[1].z;
        end
        inflight[1] = mem_view();
        e = ex_valid && !flush && (ex_alu_ctrl != 2'b10);
        n = '{e, e && ex_sets_c, e && ex_sets_z, ex_c, ex_z};
        inflight[0] = n;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        compares++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Drive inputs (called just after a falling edge), then compare against the model.
    task automatic cyc(input bit rst, input bit st, input bit fl, input bit v, input bit [1:0] ctrl,
                       input bit sc, input bit sz, input bit c, input bit z,
                       input bit ld, input bit ldz);
        reset = rst; stall = st; flush = fl; ex_valid = v; ex_alu_ctrl = ctrl;
        ex_sets_c = sc; ex_sets_z = sz; ex_c = c; ex_z = z;
        mem_is_load = ld; mem_load_z = ldz;
        #1;
        if (rst) model_clear();
        chk("carry_fwd", carry_fwd, exp_carry());
        chk("zero_fwd",  zero_fwd,  exp_zero());
        chk("arch_c",    arch_c,    ref_c);
        chk("arch_z",    arch_z,    ref_z);
    endtask

    task automatic adv();
        @(posedge clk);
        if (!reset) model_edge();
        @(negedge clk);
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        cyc(1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
        chk("reset_carry", carry_fwd, 1'b0);
        chk("reset_zero",  zero_fwd,  1'b0);
        adv();
    endtask

    initial begin
        model_clear();
        reset = 1; stall = 0; flush = 0; ex_valid = 0; ex_alu_ctrl = 0;
        ex_sets_c = 0; ex_sets_z = 0; ex_c = 0; ex_z = 0;
        mem_is_load = 0; mem_load_z = 0;
        @(negedge clk);
        do_reset();

        // ADD c=1 then ADC: carry forwarded next cycle, committed two edges later
        cyc(0, 0, 0, 1, 2'b00, 1, 1, 1, 0, 0, 0); adv();
        cyc(0, 0, 0, 1, 2'b00, 1, 1, 1, 0, 0, 0);
        chk("add_fwd_c", carry_fwd, 1'b1);
        adv();
        idle(); chk("add_arch_c_pre", arch_c, 1'b0); adv();
        idle(); chk("add_arch_c", arch_c, 1'b1); adv();
        idle(); adv();

        // Suppressed ADC must not shadow an older c=1
        do_reset();
        cyc(0, 0, 0, 1, 2'b00, 1, 1, 1, 0, 0, 0); adv();
        cyc(0, 0, 0, 1, 2'b10, 1, 1, 0, 0, 0, 0); adv();
        idle(); chk("nop_fwd_c", carry_fwd, 1'b1); adv();
        idle(); chk("nop_arch_c", arch_c, 1'b1); adv();
        idle(); chk("nop_arch_c2", arch_c, 1'b1); adv();

        // LW in MEM: loaded-zero forwarded combinationally, then committed
        cyc(0, 0, 0, 1, 2'b00, 0, 0, 0, 0, 0, 0); adv();
        cyc(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 1, 0);
        chk("lw_fwd_z0", zero_fwd, 1'b0);
        cyc(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 1, 1);
        chk("lw_fwd_z1", zero_fwd, 1'b1);
        adv();
        idle(); adv();
        idle(); chk("lw_arch_z", arch_z, 1'b1); adv();

        // Flush of ADD with older NAND z=1 in M
        do_reset();
        cyc(0, 0, 0, 1, 2'b01, 0, 1, 0, 1, 0, 0); adv();
        cyc(0, 0, 1, 1, 2'b00, 1, 1, 1, 0, 0, 0); adv();
        idle(); chk("flush_fwd_c", carry_fwd, 1'b0); chk("flush_fwd_z", zero_fwd, 1'b1); adv();
        idle(); chk("flush_arch_z", arch_z, 1'b1); chk("flush_arch_c", arch_c, 1'b0); adv();

        // Stall with pending entries; flush asserted during stall is ignored
        cyc(0, 0, 0, 1, 2'b00, 1, 1, 1, 0, 0, 0); adv();
        cyc(0, 0, 0, 1, 2'b01, 0, 1, 0, 1, 0, 0); adv();
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1, i > 0, 1, 2'b00, 1, 1, 0, 0, 0, 0);
            chk("stall_fwd_c", carry_fwd, 1'b1);
            chk("stall_fwd_z", zero_fwd,  1'b1);
            chk("stall_arch_c", arch_c, 1'b0);
            chk("stall_arch_z", arch_z, 1'b1);
            adv();
        end
        cyc(0, 0, 1, 1, 2'b00, 1, 1, 0, 0, 0, 0); adv();
        idle();
        chk("unstall_arch_c", arch_c, 1'b1);
        chk("unstall_arch_z", arch_z, 1'b0);
        chk("unstall_fwd_z",  zero_fwd, 1'b1);
        adv();

        // Mid-stream reset discards pending c=1 entries
        cyc(0, 0, 0, 1, 2'b00, 1, 0, 0, 0, 0, 0); adv();
        idle(); adv();
        idle(); adv();
        cyc(0, 0, 0, 1, 2'b00, 1, 0, 1, 0, 0, 0); adv();
        cyc(0, 0, 0, 1, 2'b00, 1, 0, 1, 0, 0, 0); adv();
        cyc(1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
        chk("mid_rst_arch_c", arch_c, 1'b0);
        chk("mid_rst_fwd_c",  carry_fwd, 1'b0);
        adv();
        idle(); adv();
        idle(); chk("post_rst_arch_c", arch_c, 1'b0); adv();

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom % 60) == 0, ($urandom % 5) == 0, ($urandom % 8) == 0,
                ($urandom % 4) != 0, 2'($urandom % 4),
                1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                ($urandom % 3) == 0, 1'($urandom));
            adv();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
        $finish;
    end

endmodule
